// File: rtl/fetch_queue_unit.sv
// Purpose : instruction-fetch front end; owns the fetch PC, issues one request at a time, queues returns.
// Latency : request cycle, ack cycle, then the entry is visible at the head on the following cycle.
// Backpr. : stall holds the head; fetch issue is gated while the queue is full; redirect flushes.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr       fetch request, held stable until imem_ack
//   imem_ack/imem_rdata      instruction return (one outstanding request)
//   stall                    decode cannot take the head this cycle
//   redirect/redirect_pc     taken branch: flush queue, restart fetch at target
//   instr_valid, instruction, currPC, pc_plus4   head of queue (zero when empty)
//   q_count                  queue occupancy
// Optional build macro FETCH_PERF_EN adds saturating redirect_cnt / stall_cnt outputs.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instruction,
  output logic [63:0]              currPC,
  output logic [63:0]              pc_plus4,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              redirect_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state;
  logic [63:0]     fpc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     q_instr [DEPTH];
  logic [63:0]     q_pc    [DEPTH];

  logic            push;
  logic            pop;
  logic [63:0]     target;

  // Branch targets are word aligned; low bits from EX are dropped.
  assign target = {redirect_pc[63:2], 2'b00};

  // A return is kept only if it answers a live request and no branch flushes it.
  assign push = (state == S_WAIT) && imem_ack && !redirect;
  assign pop  = instr_valid && !stall && !redirect;

  // Request outputs decode directly from the state register, so they are glitch-free.
  assign imem_req  = (state == S_WAIT);
  assign imem_addr = (state == S_WAIT) ? fpc : 64'h0;

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? q_instr[rd_ptr]        : 32'h0;
  assign currPC      = instr_valid ? q_pc[rd_ptr]           : 64'h0;
  assign pc_plus4    = instr_valid ? (q_pc[rd_ptr] + 64'd4) : 64'h0;
  assign q_count     = count;

  // Fetch FSM and fetch PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      fpc   <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          // Any ack seen here belongs to a request killed by reset; ignore it.
          if (redirect) begin
            fpc <= target;
          end else if (count < CW'(DEPTH)) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            state <= S_IDLE;
            fpc   <= redirect ? target : (fpc + 64'd4);
          end else if (redirect) begin
            // Request is still in flight; its ack must be swallowed in DROP.
            fpc   <= target;
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (redirect) begin
            fpc <= target;
          end
          if (imem_ack) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; redirect wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= fpc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt <= 32'h0;
      stall_cnt    <= 32'h0;
    end else begin
      if (redirect && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
      if (instr_valid && stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Purpose : directed check of fetch_queue_unit (DEPTH=4, RESET_PC=0).
// Latency : all outputs sampled 1 time unit after the rising clock edge.
// Backpr. : stall/redirect/ack driven by the sequence; memory replies one cycle after a request.
module tb_fetch_queue_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] currPC;
  logic [63:0] pc_plus4;
  logic [2:0]  q_count;

  int checks;
  int errors;

  // Memory responder state.
  logic        mem_auto;
  logic        outstanding;
  int          age;
  logic [63:0] req_addr;

  fetch_queue_unit #(
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .currPC      (currPC),
    .pc_plus4    (pc_plus4),
    .q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; model a memory that answers one cycle after accepting a request.
  // The reply word is the bitwise inverse of the low address bits.
  task automatic tick();
    @(posedge clk);
    #1;
    if (imem_ack) begin
      outstanding = 1'b0;
    end else if (outstanding) begin
      age++;
    end
    if (!outstanding && imem_req) begin
      outstanding = 1'b1;
      age         = 0;
      req_addr    = imem_addr;
    end
    if (mem_auto && outstanding && age >= 1) begin
      imem_ack   = 1'b1;
      imem_rdata = ~req_addr[31:0];
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {63'h0, instr_valid}, 64'h0);
    check({tag, "_count"}, {61'h0, q_count}, 64'h0);
    check({tag, "_instr"}, {32'h0, instruction}, 64'h0);
    check({tag, "_pc"}, currPC, 64'h0);
    check({tag, "_pc4"}, pc_plus4, 64'h0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    mem_auto    = 1'b1;
    outstanding = 1'b0;
    age         = 0;
    req_addr    = 64'h0;

    // Reset state.
    tick();
    tick();
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    check_empty("rst");

    // Cycle 0: IDLE after release.
    rst = 1'b0;
    #1;
    check("c0_req", {63'h0, imem_req}, 64'h0);
    tick();                                           // cycle 1: request 0
    check("c1_req", {63'h0, imem_req}, 64'h1);
    check("c1_addr", imem_addr, 64'h0);
    tick();                                           // cycle 2: ack
    check("c2_addr", imem_addr, 64'h0);
    check("c2_valid", {63'h0, instr_valid}, 64'h0);
    tick();                                           // cycle 3: head visible
    check("c3_valid", {63'h0, instr_valid}, 64'h1);
    check("c3_pc", currPC, 64'h0);
    check("c3_pc4", pc_plus4, 64'h4);
    check("c3_instr", {32'h0, instruction}, 64'h0000_0000_FFFF_FFFF);
    check("c3_count", {61'h0, q_count}, 64'h1);

    // Stall the head and let the queue fill.
    stall = 1'b1;
    tick();
    check("fill_addr4", imem_addr, 64'h4);
    check("fill_req4", {63'h0, imem_req}, 64'h1);
    tick();
    tick();
    tick();
    check("fill_addr8", imem_addr, 64'h8);
    repeat (5) tick();
    check("full_count", {61'h0, q_count}, 64'h4);
    check("full_req", {63'h0, imem_req}, 64'h0);
    repeat (3) tick();
    check("full_hold_req", {63'h0, imem_req}, 64'h0);
    check("full_hold_count", {61'h0, q_count}, 64'h4);
    check("full_head", currPC, 64'h0);

    // Release stall: pops in PC order, fetch restarts once a slot frees.
    stall = 1'b0;
    tick();
    check("pop1_pc", currPC, 64'h4);
    check("pop1_count", {61'h0, q_count}, 64'h3);
    check("pop1_instr", {32'h0, instruction}, 64'h0000_0000_FFFF_FFFB);
    tick();
    check("pop2_pc", currPC, 64'h8);
    check("pop2_count", {61'h0, q_count}, 64'h2);
    check("resume_req", {63'h0, imem_req}, 64'h1);
    check("resume_addr", imem_addr, 64'h10);

    // Redirect while waiting at 0x10; unaligned target gets its low bits cleared.
    stall       = 1'b1;
    mem_auto    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    tick();
    redirect = 1'b0;
    check("drop_req", {63'h0, imem_req}, 64'h0);
    check_empty("flush1");
    tick();
    tick();
    imem_ack   = 1'b1;                                // stale ack, 3 cycles after redirect
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("stale_count", {61'h0, q_count}, 64'h0);
    check("stale_req", {63'h0, imem_req}, 64'h0);
    mem_auto = 1'b1;
    stall    = 1'b0;
    tick();
    check("redir_addr", imem_addr, 64'h100);
    check("redir_req", {63'h0, imem_req}, 64'h1);
    tick();
    tick();
    check("redir_valid", {63'h0, instr_valid}, 64'h1);
    check("redir_pc", currPC, 64'h100);
    check("redir_pc4", pc_plus4, 64'h104);
    check("redir_instr", {32'h0, instruction}, 64'h0000_0000_FFFF_FEFF);

    // Build q_count=2, then redirect in the same cycle as an ack.
    stall = 1'b1;
    repeat (4) tick();
    tick();
    check("ackred_pre_count", {61'h0, q_count}, 64'h2);
    check("ackred_pre_ack", {63'h0, imem_ack}, 64'h1);
    check("ackred_pre_addr", imem_addr, 64'h108);
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    tick();
    redirect = 1'b0;
    check("ackred_count", {61'h0, q_count}, 64'h0);
    check("ackred_valid", {63'h0, instr_valid}, 64'h0);
    check("ackred_req", {63'h0, imem_req}, 64'h0);
    tick();
    check("ackred_addr", imem_addr, 64'h200);
    stall = 1'b0;
    tick();
    tick();
    check("ackred_head", currPC, 64'h200);

    // Wrap-around of the fetch PC.
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_flush_valid", {63'h0, instr_valid}, 64'h0);
    tick();
    check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    check("wrap_pc", currPC, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc4", pc_plus4, 64'h0);
    check("wrap_instr", {32'h0, instruction}, 64'h0000_0000_0000_0003);
    tick();
    check("wrap_next_addr", imem_addr, 64'h0);
    check("wrap_next_req", {63'h0, imem_req}, 64'h1);
    check("wrap_pop_count", {61'h0, q_count}, 64'h0);

    // Reset while waiting, then a late ack right after release.
    mem_auto = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_req", {63'h0, imem_req}, 64'h0);
    check("midrst_addr", imem_addr, 64'h0);
    check_empty("midrst");
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    check("late_ack_count", {61'h0, q_count}, 64'h0);
    check("restart_req", {63'h0, imem_req}, 64'h1);
    check("restart_addr", imem_addr, 64'h0);
    mem_auto = 1'b1;
    tick();
    tick();
    check("restart_pc", currPC, 64'h0);
    check("restart_count", {61'h0, q_count}, 64'h1);
    check("restart_instr", {32'h0, instruction}, 64'h0000_0000_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
